raster_cmd_sequencer: RTL and testbench
=======================================

Name: raster_cmd_sequencer

Overview:
Parametrised successor of the 8x8 rasterizer command front end. Decodes the 8-bit-style command stream (en/cmd/param) into a latched draw descriptor for grids up to 2^COORD_W per side. Adds parameter saturation, a load timeout, a protocol-error flag and a valid/ready handshake toward the rasterizer core. Sits between the pin-level input bus and the rasterizer; one descriptor in flight at a time.

Parameters:
COORD_W, 4, width of every coordinate/size field (grid up to 16x16 at default)
PARAM_W, 5, width of the param input field
MAX_COORD, 15, saturation ceiling for every captured coordinate/size; must be <= 2^COORD_W-1
TIMEOUT, 16, idle cycles allowed between parameters in LOAD before abort; 0 disables timeout

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
en  input  1  byte-valid strobe, sampled each clk
cmd  input  2  opcode: 00 NOP/param, 01 PIXEL (or CLEAR), 10 LINE, 11 RECT
param  input  PARAM_W  command argument
exec_valid  output  1  descriptor valid toward rasterizer
exec_ready  input  1  rasterizer accepts descriptor
exec_cmd  output  2  latched opcode (01/10/11)
exec_clear  output  1  descriptor is CLEAR (qualifies exec_cmd=01)
x1,y1,x2,y2  output  COORD_W each  endpoints (x2/y2 valid for LINE)
width,height  output  COORD_W each  RECT size
busy  output  1  high in LOAD or ISSUE
err  output  1  one-cycle pulse on protocol error

Behaviour:
- Reset: state IDLE; exec_valid, exec_clear, err, busy = 0; exec_cmd, all coordinate/size outputs = 0; param index and timeout counter = 0. Reset mid-operation discards partial or pending descriptor.
- Capture rule: field = min(param, MAX_COORD) truncated to COORD_W; comparison done at PARAM_W width, unsigned.
- States: IDLE, LOAD, ISSUE.
- IDLE: en=0 or cmd=00 -> stay, no err. en=1, cmd=01, param all ones -> exec_clear=1, exec_cmd=01, go ISSUE next cycle. en=1, cmd in {01,10,11} otherwise -> latch exec_cmd, x1 <= capture(param), idx=1, clear exec_clear, go LOAD.
- LOAD: needed params: PIXEL 2 (x1,y1), LINE 4 (x1,y1,x2,y2), RECT 4 (x1,y1,width,height). en=1,cmd=00 -> capture into field idx, idx+1, timeout counter cleared; final param -> ISSUE next cycle. en=0 -> counter+1; counter reaching TIMEOUT (TIMEOUT!=0) -> err pulse, back to IDLE, descriptor not issued. en=1,cmd!=00 -> err pulse, IDLE; that byte is dropped (not decoded as new command).
- ISSUE: exec_valid=1; all descriptor outputs held stable while valid. exec_ready=1 on a cycle with exec_valid=1 -> transfer; next cycle exec_valid=0, state IDLE. Byte arriving on the transfer cycle is dropped. en=1 in ISSUE (any cmd) -> err pulse, byte dropped, state unchanged.
- Unused fields (x2/y2/width/height for PIXEL) retain previous values; rasterizer ignores them.
- busy = (state != IDLE), registered with state. Latency: last param byte to exec_valid = 1 cycle; CLEAR byte to exec_valid = 1 cycle.
- err never asserted for two consecutive cycles from a single event.

Optional Feature:
AUTO_ORDER_EN: when defined, on entry to ISSUE for LINE the endpoints are swapped (x1,y1)<->(x2,y2) if x2<x1, and for RECT width/height are clipped so x1+width<=MAX_COORD and y1+height<=MAX_COORD. Adds no latency (applied in the LOAD->ISSUE transfer). When undefined, fields are issued exactly as captured.

Test Plan:
- Reset: assert rst_n=0 mid-LOAD of LINE -> all outputs 0, state IDLE, next PIXEL(3,4) issues normally with x1=3,y1=4.
- PIXEL: en/cmd=01/param=3, then en/00/param=20 -> exec_valid 1 cycle later, exec_cmd=01, x1=3, y1=15 (saturated); held 3 cycles with exec_ready=0, released on exec_ready=1.
- CLEAR: en/01/param=31 -> next cycle exec_valid=1, exec_clear=1; exec_ready=1 -> exec_valid=0 next cycle.
- LINE with AUTO_ORDER_EN: params 9,2,1,7 -> x1=1,y1=7,x2=9,y2=2; without macro -> 9,2,1,7.
- Timeout: RECT first byte then en=0 for 16 cycles -> err pulse on 16th, IDLE, exec_valid never asserted.
- Protocol error: in LOAD send en/10 -> err pulse, IDLE, byte dropped; en during ISSUE -> err pulse, descriptor unchanged.

Source files
------------

// File: rtl/raster_cmd_sequencer.sv
// raster_cmd_sequencer: decodes en/cmd/param bytes into a latched draw descriptor with valid/ready issue (optional AUTO_ORDER_EN)
module raster_cmd_sequencer #(
  parameter int COORD_W   = 4,
  parameter int PARAM_W   = 5,
  parameter int MAX_COORD = 15,
  parameter int TIMEOUT   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [1:0]         cmd,
  input  logic [PARAM_W-1:0] param,
  output logic               exec_valid,
  input  logic               exec_ready,
  output logic [1:0]         exec_cmd,
  output logic               exec_clear,
  output logic [COORD_W-1:0] x1,
  output logic [COORD_W-1:0] y1,
  output logic [COORD_W-1:0] x2,
  output logic [COORD_W-1:0] y2,
  output logic [COORD_W-1:0] width,
  output logic [COORD_W-1:0] height,
  output logic               busy,
  output logic               err
);
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  typedef enum logic [1:0] {IDLE, LOAD, ISSUE} state_t;
  state_t state, state_n;
  logic [1:0] idx;
  logic [CW-1:0] cnt;
  logic [COORD_W-1:0] cap, nx1, ny1, nx2, ny2, nw, nh;
  logic clr, start, capture, err_n, last;
  assign cap  = (param > PARAM_W'(MAX_COORD)) ? COORD_W'(MAX_COORD) : COORD_W'(param);
  assign last = (exec_cmd == 2'b01) ? (idx == 2'd1) : (idx == 2'd3);
  // next state and control strobes
  always_comb begin
    state_n = state;
    clr     = 1'b0;
    start   = 1'b0;
    capture = 1'b0;
    err_n   = 1'b0;
    case (state)
      IDLE: if (en && cmd != 2'b00) begin
        clr     = (cmd == 2'b01) && (&param);
        start   = !clr;
        state_n = clr ? ISSUE : LOAD;
      end
      LOAD: if (en && cmd != 2'b00) begin
        err_n   = 1'b1;
        state_n = IDLE;
      end else if (en) begin
        capture = 1'b1;
        state_n = last ? ISSUE : LOAD;
      end else if (TIMEOUT != 0 && int'(cnt) == TIMEOUT - 1) begin
        err_n   = 1'b1;
        state_n = IDLE;
      end
      ISSUE: begin
        err_n   = en;
        state_n = exec_ready ? IDLE : ISSUE;
      end
      default: state_n = IDLE;
    endcase
  end
  // field update, including optional ordering/clipping on the final byte
  always_comb begin
    nx1 = start ? cap : x1;
    ny1 = (capture && idx == 2'd1) ? cap : y1;
    nx2 = (capture && idx == 2'd2 && exec_cmd == 2'b10) ? cap : x2;
    ny2 = (capture && idx == 2'd3 && exec_cmd == 2'b10) ? cap : y2;
    nw  = (capture && idx == 2'd2 && exec_cmd == 2'b11) ? cap : width;
    nh  = (capture && idx == 2'd3 && exec_cmd == 2'b11) ? cap : height;
`ifdef AUTO_ORDER_EN
    if (capture && last && exec_cmd == 2'b10 && nx2 < nx1) begin
      {nx1, nx2} = {nx2, nx1};
      {ny1, ny2} = {ny2, ny1};
    end
    if (capture && last && exec_cmd == 2'b11) begin
      nw = (int'(nx1) + int'(nw) > MAX_COORD) ? COORD_W'(MAX_COORD - int'(nx1)) : nw;
      nh = (int'(ny1) + int'(nh) > MAX_COORD) ? COORD_W'(MAX_COORD - int'(ny1)) : nh;
    end
`endif
  end
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  // registered outputs, param index and idle counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy       <= 1'b0;
      exec_valid <= 1'b0;
      err        <= 1'b0;
      exec_cmd   <= 2'b00;
      exec_clear <= 1'b0;
      idx        <= 2'd0;
      cnt        <= '0;
      x1         <= '0;
      y1         <= '0;
      x2         <= '0;
      y2         <= '0;
      width      <= '0;
      height     <= '0;
    end else begin
      busy       <= state_n != IDLE;
      exec_valid <= state_n == ISSUE;
      err        <= err_n;
      idx        <= start ? 2'd1 : capture ? idx + 2'd1 : idx;
      cnt        <= (state == LOAD && !en && state_n == LOAD) ? cnt + 1'b1 : '0;
      if (clr || start) begin
        exec_cmd   <= clr ? 2'b01 : cmd;
        exec_clear <= clr;
      end
      x1     <= nx1;
      y1     <= ny1;
      x2     <= nx2;
      y2     <= ny2;
      width  <= nw;
      height <= nh;
    end
  end
endmodule

// File: tb/tb_raster_cmd_sequencer.sv
// tb_raster_cmd_sequencer: vector table, corner sequences and randomized run against a transaction-level model
module tb_raster_cmd_sequencer;
  localparam int MAX = 15;
  localparam int TO  = 16;
`ifdef AUTO_ORDER_EN
  localparam bit AO = 1'b1;
`else
  localparam bit AO = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, exec_ready = 1'b0;
  logic [1:0] cmd = 2'b00;
  logic [4:0] param = 5'd0;
  logic exec_valid, exec_clear, busy, err;
  logic [1:0] exec_cmd;
  logic [3:0] x1, y1, x2, y2, width, height;
  int tests = 0, fails = 0;
  int m_mode, m_cmd, m_clear, m_idle, m_err;
  int mf[6];
  int q[$];
  raster_cmd_sequencer dut (
    .clk(clk), .rst_n(rst_n), .en(en), .cmd(cmd), .param(param),
    .exec_valid(exec_valid), .exec_ready(exec_ready), .exec_cmd(exec_cmd),
    .exec_clear(exec_clear), .x1(x1), .y1(y1), .x2(x2), .y2(y2),
    .width(width), .height(height), .busy(busy), .err(err)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic e; logic [1:0] c; logic [4:0] p; logic r;
    logic v, b, er, d, cl; logic [1:0] ec; logic [3:0] ex1, ey1, ex2, ey2;
  } vec_t;
  vec_t tbl[$];
  function automatic vec_t mk(input logic e, input logic [1:0] c, input logic [4:0] p, input logic r,
                              input logic v, input logic b, input logic er, input logic d, input logic cl,
                              input logic [1:0] ec, input int a, input int bb, input int cc, input int dd);
    vec_t t;
    t = '{e: e, c: c, p: p, r: r, v: v, b: b, er: er, d: d, cl: cl, ec: ec,
          ex1: 4'(a), ey1: 4'(bb), ex2: 4'(cc), ey2: 4'(dd)};
    return t;
  endfunction
  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  function automatic int sat(input int p);
    return (p > MAX) ? MAX : p;
  endfunction
  function automatic int min2(input int a, input int b);
    return (a < b) ? a : b;
  endfunction
  task automatic model_reset();
    m_mode = 0; m_cmd = 0; m_clear = 0; m_idle = 0; m_err = 0;
    q.delete();
  endtask
  task automatic model_finish();
    mf[0] = q[0];
    mf[1] = q[1];
    if (m_cmd == 2) begin
      mf[2] = q[2]; mf[3] = q[3];
      if (AO && q[2] < q[0]) begin
        mf[0] = q[2]; mf[1] = q[3]; mf[2] = q[0]; mf[3] = q[1];
      end
    end
    if (m_cmd == 3) begin
      mf[4] = AO ? min2(q[2], MAX - q[0]) : q[2];
      mf[5] = AO ? min2(q[3], MAX - q[1]) : q[3];
    end
  endtask
  task automatic model_step(input logic e, input int c, input int p, input logic r);
    m_err = 0;
    if (m_mode == 0) begin
      if (e && c != 0) begin
        if (c == 1 && p == 31) begin
          m_clear = 1; m_cmd = 1; m_mode = 2;
        end else begin
          m_clear = 0; m_cmd = c; q.delete(); q.push_back(sat(p)); m_idle = 0; m_mode = 1;
        end
      end
    end else if (m_mode == 1) begin
      if (e && c != 0) begin
        m_err = 1; m_mode = 0;
      end else if (e) begin
        q.push_back(sat(p)); m_idle = 0;
        if (q.size() == ((m_cmd == 1) ? 2 : 4)) begin
          model_finish(); m_mode = 2;
        end
      end else begin
        m_idle++;
        if (m_idle == TO) begin
          m_err = 1; m_mode = 0;
        end
      end
    end else begin
      m_err = e ? 1 : 0;
      if (r) m_mode = 0;
    end
  endtask
  task automatic drive(input logic e, input logic [1:0] c, input logic [4:0] p, input logic r);
    en = e; cmd = c; param = p; exec_ready = r;
    @(posedge clk);
    model_step(e, int'(c), int'(p), r);
    #1;
  endtask
  task automatic model_check();
    chk("valid", exec_valid, (m_mode == 2) ? 1 : 0);
    chk("busy", busy, (m_mode != 0) ? 1 : 0);
    chk("err", err, m_err);
    if (m_mode == 2) begin
      chk("cmd", exec_cmd, m_cmd);
      chk("clear", exec_clear, m_clear);
      if (!m_clear) begin
        chk("x1", x1, mf[0]);
        chk("y1", y1, mf[1]);
        if (m_cmd == 2) begin chk("x2", x2, mf[2]); chk("y2", y2, mf[3]); end
        if (m_cmd == 3) begin chk("width", width, mf[4]); chk("height", height, mf[5]); end
      end
    end
  endtask
  task automatic do_reset();
    #2 rst_n = 1'b0;
    en = 1'b0; cmd = 2'b00; param = 5'd0; exec_ready = 1'b0;
    #1;
    chk("rst_valid", exec_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_cmd", exec_cmd, 0);
    chk("rst_clear", exec_clear, 0);
    chk("rst_fields", {x1, y1, x2, y2, width, height}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
  endtask
  initial begin
    int ep;
    do_reset();
    drive(1, 2'b10, 5'd9, 0);
    drive(1, 2'b00, 5'd2, 0);
    chk("midline_busy", busy, 1);
    do_reset();
    drive(1, 2'b01, 5'd3, 0);
    drive(1, 2'b00, 5'd4, 0);
    chk("pix34_valid", exec_valid, 1);
    chk("pix34_x1", x1, 3);
    chk("pix34_y1", y1, 4);
    chk("pix34_cmd", exec_cmd, 1);
    drive(0, 2'b00, 5'd0, 1);
    chk("pix34_release", exec_valid, 0);
    tbl.push_back(mk(1, 2'b01, 3,  0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 2'b00, 20, 0, 1, 1, 0, 1, 0, 1, 3, 15, 0, 0));
    tbl.push_back(mk(0, 2'b00, 0,  0, 1, 1, 0, 1, 0, 1, 3, 15, 0, 0));
    tbl.push_back(mk(0, 2'b00, 0,  0, 1, 1, 0, 1, 0, 1, 3, 15, 0, 0));
    tbl.push_back(mk(0, 2'b00, 0,  1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 2'b01, 31, 0, 1, 1, 0, 1, 1, 1, 3, 15, 0, 0));
    tbl.push_back(mk(0, 2'b00, 0,  1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 2'b10, 9,  0, 0, 1, 0, 0, 0, 2, 0, 0, 0, 0));
    tbl.push_back(mk(1, 2'b00, 2,  0, 0, 1, 0, 0, 0, 2, 0, 0, 0, 0));
    tbl.push_back(mk(1, 2'b00, 1,  0, 0, 1, 0, 0, 0, 2, 0, 0, 0, 0));
    tbl.push_back(mk(1, 2'b00, 7,  0, 1, 1, 0, 1, 0, 2, AO ? 1 : 9, AO ? 7 : 2, AO ? 9 : 1, AO ? 2 : 7));
    tbl.push_back(mk(0, 2'b00, 0,  1, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0));
    tbl.push_back(mk(1, 2'b11, 5,  0, 0, 1, 0, 0, 0, 3, 0, 0, 0, 0));
    tbl.push_back(mk(1, 2'b10, 0,  0, 0, 0, 1, 0, 0, 3, 0, 0, 0, 0));
    tbl.push_back(mk(1, 2'b00, 0,  0, 0, 0, 0, 0, 0, 3, 0, 0, 0, 0));
    tbl.push_back(mk(1, 2'b01, 6,  0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 2'b00, 8,  0, 1, 1, 0, 1, 0, 1, 6, 8, AO ? 9 : 1, AO ? 2 : 7));
    tbl.push_back(mk(1, 2'b11, 4,  0, 1, 1, 1, 1, 0, 1, 6, 8, AO ? 9 : 1, AO ? 2 : 7));
    tbl.push_back(mk(0, 2'b00, 0,  0, 1, 1, 0, 1, 0, 1, 6, 8, AO ? 9 : 1, AO ? 2 : 7));
    tbl.push_back(mk(0, 2'b00, 0,  1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    foreach (tbl[i]) begin
      drive(tbl[i].e, tbl[i].c, tbl[i].p, tbl[i].r);
      chk($sformatf("v%0d_valid", i), exec_valid, tbl[i].v);
      chk($sformatf("v%0d_busy", i), busy, tbl[i].b);
      chk($sformatf("v%0d_err", i), err, tbl[i].er);
      if (tbl[i].d) begin
        chk($sformatf("v%0d_cmd", i), exec_cmd, tbl[i].ec);
        chk($sformatf("v%0d_clear", i), exec_clear, tbl[i].cl);
        chk($sformatf("v%0d_x1", i), x1, tbl[i].ex1);
        chk($sformatf("v%0d_y1", i), y1, tbl[i].ey1);
        chk($sformatf("v%0d_x2", i), x2, tbl[i].ex2);
        chk($sformatf("v%0d_y2", i), y2, tbl[i].ey2);
      end
    end
    drive(1, 2'b11, 5'd5, 0);
    for (int k = 1; k <= TO; k++) begin
      drive(0, 2'b00, 5'd0, 0);
      chk($sformatf("to%0d_err", k), err, (k == TO) ? 1 : 0);
      chk($sformatf("to%0d_valid", k), exec_valid, 0);
    end
    chk("to_busy", busy, 0);
    drive(0, 2'b00, 5'd0, 1);
    chk("to_err_clear", err, 0);
    chk("to_no_valid", exec_valid, 0);
    drive(1, 2'b11, 5'd10, 0);
    drive(1, 2'b00, 5'd12, 0);
    drive(1, 2'b00, 5'd9, 0);
    drive(1, 2'b00, 5'd31, 1);
    chk("rect_valid", exec_valid, 1);
    chk("rect_w", width, AO ? 5 : 9);
    chk("rect_h", height, AO ? 3 : 15);
    drive(1, 2'b01, 5'd31, 1);
    chk("xfer_drop_valid", exec_valid, 0);
    chk("xfer_drop_busy", busy, 0);
    do_reset();
    ep = 60;
    for (int n = 0; n < 4000; n++) begin
      logic e, r;
      logic [1:0] c;
      if (n % 64 == 0) ep = (n % 192 == 0) ? 5 : (n % 128 == 0) ? 95 : 60;
      e = ($urandom_range(99) < ep);
      c = ($urandom_range(99) < 70) ? 2'b00 : 2'($urandom_range(3));
      r = ($urandom_range(99) < 30);
      drive(e, c, 5'($urandom_range(31)), r);
      model_check();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
